// File: rtl/xdma_axi_adapter_pkg.sv
// Shared definitions for the xDMA AXI adapter blocks.
package xdma_axi_adapter_pkg;

  localparam int unsigned IdTrackerDefaultN = 8;

  // Index width for an n-entry pool; a single-entry pool still gets a 1-bit index port.
  function automatic int unsigned id_idx_width(input int unsigned n);
    int unsigned m;
    m = (n > 1) ? n : 1;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/find_first_one_idx.sv
// Priority encoder: index of the lowest set bit of in_i, valid_o when any bit is set.
module find_first_one_idx
  import xdma_axi_adapter_pkg::*;
#(
  parameter int unsigned N    = IdTrackerDefaultN,
  parameter int unsigned IdxW = id_idx_width(N)
) (
  input  logic [N-1:0]    in_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    valid_o = |in_i;
    idx_o   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (in_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/axi_id_tracker.sv
// Outstanding AXI ID slot pool: allocates the lowest free slot, releases by index.
// Optional AXI_ID_TRACKER_ERR_EN builds in the sticky illegal-release flag on err_o.
module axi_id_tracker
  import xdma_axi_adapter_pkg::*;
#(
  parameter int unsigned N    = IdTrackerDefaultN,
  parameter int unsigned IdxW = id_idx_width(N),
  parameter int unsigned CntW = $clog2(N + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            alloc_valid_o,
  input  logic            alloc_ready_i,
  output logic [IdxW-1:0] alloc_idx_o,
  input  logic            release_valid_i,
  input  logic [IdxW-1:0] release_idx_i,
  input  logic            flush_i,
  output logic [N-1:0]    busy_mask_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            err_o
);

  logic [N-1:0]    busy_q, busy_d;
  logic [CntW-1:0] count_q, count_d;
  logic [N-1:0]    alloc_oh, rel_oh;
  logic            alloc_fire, rel_legal;

  find_first_one_idx #(
    .N    (N),
    .IdxW (IdxW)
  ) u_find_free (
    .in_i    (~busy_q),
    .valid_o (alloc_valid_o),
    .idx_o   (alloc_idx_o)
  );

  assign alloc_fire = alloc_valid_o & alloc_ready_i;

  // Index-to-one-hot decode; indices >= N match no slot, which is the range check.
  always_comb begin
    alloc_oh = '0;
    rel_oh   = '0;
    for (int i = 0; i < int'(N); i++) begin
      alloc_oh[i] = (alloc_idx_o == IdxW'(i));
      rel_oh[i]   = release_valid_i && (release_idx_i == IdxW'(i));
    end
  end

  assign rel_legal = |(rel_oh & busy_q);

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (flush_i) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire) busy_d = busy_d | alloc_oh;
      if (rel_legal)  busy_d = busy_d & ~rel_oh;
      if (alloc_fire && !rel_legal) begin
        count_d = count_q + CntW'(1);
      end else if (!alloc_fire && rel_legal) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

`ifdef AXI_ID_TRACKER_ERR_EN
  logic err_q, err_d;

  // Sticky until reset; flush deliberately leaves it alone.
  assign err_d = err_q | (release_valid_i & ~rel_legal);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_mask_o = busy_q;
  assign count_o     = count_q;
  assign full_o      = (count_q == CntW'(N));
  assign empty_o     = (count_q == '0);

endmodule

// File: tb/tb_axi_id_tracker.sv
// Randomized scoreboard bench for axi_id_tracker (N=5 exercises out-of-range indices).
module tb_axi_id_tracker;

  localparam int unsigned N    = 5;
  localparam int unsigned IdxW = 3;
  localparam int unsigned CntW = 3;
`ifdef AXI_ID_TRACKER_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alloc_valid;
  logic            alloc_ready = 1'b0;
  logic [IdxW-1:0] alloc_idx;
  logic            release_valid = 1'b0;
  logic [IdxW-1:0] release_idx = '0;
  logic            flush = 1'b0;
  logic [N-1:0]    busy_mask;
  logic [CntW-1:0] count;
  logic            full, empty, err;

  axi_id_tracker #(
    .N (N)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .alloc_valid_o   (alloc_valid),
    .alloc_ready_i   (alloc_ready),
    .alloc_idx_o     (alloc_idx),
    .release_valid_i (release_valid),
    .release_idx_i   (release_idx),
    .flush_i         (flush),
    .busy_mask_o     (busy_mask),
    .count_o         (count),
    .full_o          (full),
    .empty_o         (empty),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit   valid;
    int   idx;
    int   mask;
    int   cnt;
    bit   err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a set of busy slots plus a sticky error bit.
  bit m_busy[N];
  bit m_err;

  function automatic int lowest_free();
    for (int i = 0; i < int'(N); i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int n_busy();
    int c = 0;
    for (int i = 0; i < int'(N); i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int mask_of();
    int m = 0;
    for (int i = 0; i < int'(N); i++) if (m_busy[i]) m += (1 << i);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: publish the expected visible state, drive inputs, advance the model.
  task automatic step(input bit ar, input bit rv, input int ri, input bit fl);
    exp_t e;
    int   lf;
    bit   legal;
    @(negedge clk);
    lf      = lowest_free();
    e.valid = (lf >= 0);
    e.idx   = lf;
    e.mask  = mask_of();
    e.cnt   = n_busy();
    e.err   = m_err;
    exp_q.push_back(e);
    alloc_ready   = ar;
    release_valid = rv;
    release_idx   = IdxW'(ri);
    flush         = fl;
    legal = rv && (ri < int'(N)) && m_busy[ri];
    if (rv && !legal && ErrEn) m_err = 1'b1;
    if (fl) begin
      for (int i = 0; i < int'(N); i++) m_busy[i] = 1'b0;
    end else begin
      if (ar && lf >= 0) m_busy[lf] = 1'b1;
      if (legal) m_busy[ri] = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("alloc_valid", 32'(alloc_valid), 32'(e.valid));
        if (e.valid) check("alloc_idx", 32'(alloc_idx), e.idx);
        check("busy_mask", 32'(busy_mask), e.mask);
        check("count", 32'(count), e.cnt);
        check("full", 32'(full), 32'(e.cnt == int'(N)));
        check("empty", 32'(empty), 32'(e.cnt == 0));
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int ri, base;
    for (int i = 0; i < int'(N); i++) m_busy[i] = 1'b0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill the pool, then idle while full with ready held.
    for (int i = 0; i < int'(N); i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 2, 0);              // release from full
    step(1, 1, 0, 0);              // alloc slot 2 and release slot 0 together
    step(0, 1, 0, 0);              // release of a free slot
    step(0, 1, 7, 0);              // out-of-range release
    step(1, 0, 0, 1);              // flush wins over alloc
    step(0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      base = $urandom_range(0, 7);
      ri   = base;
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < int'(N); k++) begin
          if (m_busy[(base + k) % int'(N)]) begin
            ri = (base + k) % int'(N);
            break;
          end
        end
      end
      if ($urandom_range(0, 63) == 0) step($urandom_range(0, 1) != 0, 0, 0, 1);
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, ri, 0);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset between clock edges must clear state without an edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_mask", 32'(busy_mask), 0);
    check("async_rst_valid", 32'(alloc_valid), 1);
    check("async_rst_idx", 32'(alloc_idx), 0);
    check("async_rst_count", 32'(count), 0);
    check("async_rst_empty", 32'(empty), 1);
    check("async_rst_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_id_tracker.md
# axi_id_tracker

Tracks a pool of N outstanding-transaction slots (AXI IDs) for the xDMA AXI adapter. The allocation side offers the lowest free slot through a valid/ready handshake, priority-encoding the free mask to an index. The release side decodes a returned index back into the slot mask, so it is the index-to-mask counterpart of the allocation encoder. The block sits between the xDMA request issuer (allocates an ID per AXI burst) and the response path (releases the ID on last beat).

## Interface
- N, default 8: number of slots, N >= 1.
- IdxW, default $clog2(N>1?N:1): index width, derived; never overridden.
- CntW, default $clog2(N+1): occupancy counter width, derived.

- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- alloc_valid_o  out  1  a free slot is offered.
- alloc_ready_i  in  1  consumer takes the offered slot.
- alloc_idx_o  out  IdxW  offered slot index, meaningful only while alloc_valid_o.
- release_valid_i  in  1  a slot is being returned this cycle.
- release_idx_i  in  IdxW  returned slot index.
- flush_i  in  1  synchronous clear of all slots.
- busy_mask_o  out  N  registered busy mask, bit i = slot i allocated.
- count_o  out  CntW  number of busy slots.
- full_o  out  1  count_o == N.
- empty_o  out  1  count_o == 0.
- err_o  out  1  sticky illegal-release flag (see Configuration).

## Operation
- State: busy mask (N flops), occupancy counter (CntW flops), err flag.
- alloc_valid_o = |~busy. alloc_idx_o = lowest i with busy[i]==0 (combinational from the registered mask).
- Alloc fire = alloc_valid_o & alloc_ready_i: set busy[alloc_idx_o], count +1.
- Legal release = release_valid_i & release_idx_i < N & busy[release_idx_i]: clear that bit, count -1.
- Illegal release (index >= N or slot already free): mask and count unchanged; err flag set.
- Alloc fire and legal release in the same cycle: both applied, count unchanged. They can never target the same slot, because alloc picks a free slot and a legal release targets a busy one.
- flush_i: next cycle mask = 0, count = 0. It has priority over alloc and release in the same cycle, and the err flag is not cleared.
- alloc_ready_i while alloc_valid_o is low: no effect.
- count_o always equals popcount(busy_mask_o). Implement it as an incremental counter, not a popcount tree.

## Timing
- Reset values: busy_mask_o 0, count_o 0, empty_o 1, full_o 0 (1 only if N==0, which is illegal), err_o 0, alloc_valid_o 1, alloc_idx_o 0.
- Allocation has 0-cycle offer latency and takes effect in the mask one cycle after fire.
- A released slot becomes offerable the cycle after release. It is never offered in the release cycle.
- alloc_idx_o may change while alloc_valid_o is high and alloc_ready_i is low, when a lower slot is released. The consumer samples the index only on fire. This is a deliberate deviation from AXI stability rules.
- When full, alloc_valid_o is low. A release while full raises alloc_valid_o the next cycle.
- Reset asserted mid-operation clears all state asynchronously. Outputs take reset values with no clock edge.
- full_o and empty_o are decoded from the registered count and carry no extra latency.

## Configuration
- AXI_ID_TRACKER_ERR_EN defined: illegal-release detection is built in, and err_o is sticky until rst_i.
- Not defined: err_o is tied 0 and the detection logic is removed. Illegal releases are still ignored: an out-of-range index is dropped, and a release of a free slot leaves it free.

## Structure
- Shared package xdma_axi_adapter_pkg holds the localparam IdTrackerDefaultN = 8 and the index-width helper function, used as (N>1?N:1) clog2.
- Sub-module: find_first_one_idx, instantiated with N=N, input ~busy. Its valid_o drives alloc_valid_o and its idx_o drives alloc_idx_o.
- The release decode (index to one-hot, with range check) stays inline.

## Test plan
- N=4, reset then alloc_ready_i=1 for 4 cycles -> alloc_idx_o 0,1,2,3 on successive cycles; busy_mask_o 4'b1111; full_o=1, alloc_valid_o=0, count_o=4.
- N=4 full, release idx 2 -> next cycle busy_mask_o=4'b1011, alloc_valid_o=1, alloc_idx_o=2, count_o=3.
- N=4 busy_mask_o=4'b0011, same cycle alloc fire (idx 2) and release idx 0 -> busy_mask_o=4'b0110, count_o stays 2, next offer idx 0.
- N=4 busy_mask_o=4'b0001, release idx 3 (free) -> mask unchanged, err_o=1 and stays 1 (with AXI_ID_TRACKER_ERR_EN); without the macro, err_o=0.
- N=5, release_idx_i=7 -> ignored, err_o=1. Then flush_i together with alloc fire -> busy_mask_o=0, count_o=0, empty_o=1.
- N=1: alloc fire -> full_o=1, alloc_idx_o=0. Assert rst_i asynchronously mid-cycle -> busy_mask_o=0, alloc_valid_o=1 before the next clock edge.
